// File: rtl/instr_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// instr_fetch_sequencer
//
// Owns the program counter of the multi-cycle core. Each instruction runs
// through one pass of IDLE -> REQ -> WAIT -> ISSUE -> EXEC: the PC is sent to
// instruction memory over a valid/ready request channel, the returned word is
// captured and offered to decode together with its address, and the sequencer
// then waits for the branch unit to report the next PC before starting again.
// A misaligned next PC parks the sequencer in FAULT until reset.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   fetch_enable      permits a new fetch to start (sampled in IDLE only)
//   imem_req_*        fetch request channel (valid/ready, addr = current PC)
//   imem_resp_*       single-cycle response pulse carrying the fetched word
//   instr_valid/ready decode handshake; instr/instr_addr held until accepted
//   next_pc_valid/pc  branch unit result, consumed in EXEC only
//   misaligned_err    sticky flag, set when next_pc[1:0] != 0 was received
//   retired_count     number of instructions completed since reset (wraps)
// ---------------------------------------------------------------------------
module instr_fetch_sequencer #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_enable,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              next_pc_valid,
  input  logic [ADDR_W-1:0] next_pc,
  output logic              misaligned_err,
  output logic [31:0]       retired_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    ISSUE = 3'd3,
    EXEC  = 3'd4,
    FAULT = 3'd5
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic [ADDR_W-1:0]   pc_r;
  logic [31:0]         instr_r;
  logic [ADDR_W-1:0]   instr_addr_r;
  logic                misaligned_err_r;
  logic [31:0]         retired_count_r;

  logic                capture_s;  // response accepted in WAIT
  logic                retire_s;   // aligned next PC accepted in EXEC
  logic                fault_s;    // misaligned next PC accepted in EXEC

  // Next-state and per-cycle action decode.
  always_comb begin
    next_state_s = state_r;
    capture_s    = 1'b0;
    retire_s     = 1'b0;
    fault_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (fetch_enable) begin
          next_state_s = REQ;
        end else begin
          next_state_s = IDLE;
        end
      end
      REQ: begin
        // imem_req_valid is implied by being in REQ.
        if (imem_req_ready) begin
          next_state_s = WAIT;
        end else begin
          next_state_s = REQ;
        end
      end
      WAIT: begin
        // Only WAIT looks at the response, so a stray pulse during REQ or
        // the acceptance cycle is never captured.
        if (imem_resp_valid) begin
          capture_s    = 1'b1;
          next_state_s = ISSUE;
        end else begin
          next_state_s = WAIT;
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          next_state_s = EXEC;
        end else begin
          next_state_s = ISSUE;
        end
      end
      EXEC: begin
        if (next_pc_valid) begin
          if (next_pc[1:0] == 2'b00) begin
            retire_s     = 1'b1;
            next_state_s = IDLE;
          end else begin
            fault_s      = 1'b1;
            next_state_s = FAULT;
          end
        end else begin
          next_state_s = EXEC;
        end
      end
      FAULT: begin
        next_state_s = FAULT;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Program counter: only an aligned branch-unit result moves it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r <= RESET_PC;
    end else if (retire_s) begin
      pc_r <= next_pc;
    end else begin
      pc_r <= pc_r;
    end
  end

  // Held instruction word and its address, loaded when the response lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_r      <= 32'h0000_0000;
      instr_addr_r <= RESET_PC;
    end else if (capture_s) begin
      instr_r      <= imem_resp_data;
      instr_addr_r <= pc_r;
    end else begin
      instr_r      <= instr_r;
      instr_addr_r <= instr_addr_r;
    end
  end

  // Sticky misalignment flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misaligned_err_r <= 1'b0;
    end else if (fault_s) begin
      misaligned_err_r <= 1'b1;
    end else begin
      misaligned_err_r <= misaligned_err_r;
    end
  end

  // Retired-instruction counter; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_count_r <= 32'h0000_0000;
    end else if (retire_s) begin
      retired_count_r <= retired_count_r + 32'd1;
    end else begin
      retired_count_r <= retired_count_r;
    end
  end

  // Request and decode valids depend only on state, keeping inputs off
  // every output path; the address comes straight from the PC register.
  assign imem_req_valid = (state_r == REQ);
  assign imem_req_addr  = pc_r;
  assign instr_valid    = (state_r == ISSUE);
  assign instr          = instr_r;
  assign instr_addr     = instr_addr_r;
  assign misaligned_err = misaligned_err_r;
  assign retired_count  = retired_count_r;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
module tb_instr_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_enable;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_addr;
  logic        next_pc_valid;
  logic [31:0] next_pc;
  logic        misaligned_err;
  logic [31:0] retired_count;

  int total = 0;
  int bad   = 0;

  // Reference state: architectural view of the sequencer.
  logic [31:0] model_pc;
  logic [31:0] model_retired;
  logic        model_err;

  instr_fetch_sequencer #(.ADDR_W(32), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_enable   (fetch_enable),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_addr     (instr_addr),
    .next_pc_valid  (next_pc_valid),
    .next_pc        (next_pc),
    .misaligned_err (misaligned_err),
    .retired_count  (retired_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    model_pc      = RST_PC;
    model_retired = 32'd0;
    model_err     = 1'b0;
  endtask

  // Wait (bounded) for a request, stall it, accept it.
  task automatic request_phase(input int rdy_dly);
    int n;
    logic [31:0] junk;
    n = 0;
    while (imem_req_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", 32'(imem_req_valid), 32'd1);
    check("req_addr", imem_req_addr, model_pc);
    for (int i = 0; i < rdy_dly; i++) begin
      imem_req_ready = 1'b0;
      // an in-flight fetch must survive fetch_enable dropping
      fetch_enable   = 1'($urandom_range(0, 1));
      tick();
      check("req_hold_valid", 32'(imem_req_valid), 32'd1);
      check("req_hold_addr", imem_req_addr, model_pc);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    check("no_dup_req", 32'(imem_req_valid), 32'd0);
    junk = $urandom();
    junk[0] = 1'b1;
    // branch-unit results outside EXEC must be ignored
    next_pc_valid = 1'b1;
    next_pc       = junk;
  endtask

  // Deliver the response after rsp_dly idle cycles, then run decode handshake.
  task automatic response_issue(input logic [31:0] data, input int rsp_dly, input int ird_dly);
    for (int i = 0; i < rsp_dly; i++) begin
      tick();
      check("wait_no_valid", 32'(instr_valid), 32'd0);
    end
    next_pc_valid   = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    tick();
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom();
    check("instr_valid", 32'(instr_valid), 32'd1);
    check("instr", instr, data);
    check("instr_addr", instr_addr, model_pc);
    for (int i = 0; i < ird_dly; i++) begin
      tick();
      check("issue_hold_valid", 32'(instr_valid), 32'd1);
      check("issue_hold_instr", instr, data);
      check("issue_hold_addr", instr_addr, model_pc);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("issue_done", 32'(instr_valid), 32'd0);
  endtask

  // Idle some cycles in EXEC then present the branch result.
  task automatic exec_phase(input int exec_dly, input logic [31:0] npc);
    fetch_enable = 1'b1;
    for (int i = 0; i < exec_dly; i++) begin
      tick();
      check("exec_wait_count", retired_count, model_retired);
    end
    next_pc_valid = 1'b1;
    next_pc       = npc;
    tick();
    next_pc_valid = 1'b0;
    if (npc % 32'd4 == 32'd0) begin
      model_pc      = npc;
      model_retired = model_retired + 32'd1;
    end else begin
      model_err = 1'b1;
    end
    check("retired_count", retired_count, model_retired);
    check("misaligned_err", 32'(misaligned_err), 32'(model_err));
  endtask

  initial begin
    logic [31:0] npc;
    reset = 1'b1;
    fetch_enable = 1'b0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'd0;
    instr_ready = 1'b0;
    next_pc_valid = 1'b0;
    next_pc = 32'd0;
    model_reset();
    tick();
    tick();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_addr", instr_addr, RST_PC);
    check("rst_req_addr", imem_req_addr, RST_PC);
    check("rst_err", 32'(misaligned_err), 32'd0);
    check("rst_count", retired_count, 32'd0);
    reset = 1'b0;
    fetch_enable = 1'b1;

    // first instruction from RESET_PC with a zero-wait memory
    request_phase(0);
    response_issue(32'h0050_0093, 0, 0);
    exec_phase(1, 32'h0000_0104);
    // sequential then taken branch
    request_phase(0);
    response_issue(32'h0000_0013, 0, 0);
    exec_phase(0, 32'h0000_0080);
    // stalled request and stalled decode
    request_phase(3);
    response_issue(32'hDEAD_BEEF, 2, 4);
    exec_phase(2, 32'h0000_0084);

    // misaligned next PC -> FAULT
    request_phase(1);
    response_issue(32'h1234_5678, 1, 1);
    exec_phase(0, 32'h0000_0106);
    for (int i = 0; i < 20; i++) begin
      next_pc_valid = 1'b1;
      next_pc = 32'h0000_0200;
      tick();
      check("fault_no_req", 32'(imem_req_valid), 32'd0);
      check("fault_no_instr", 32'(instr_valid), 32'd0);
      check("fault_err_sticky", 32'(misaligned_err), 32'd1);
    end
    next_pc_valid = 1'b0;
    check("fault_count", retired_count, model_retired);
    reset = 1'b1;
    #1;
    model_reset();
    check("async_rst_err", 32'(misaligned_err), 32'd0);
    tick();
    reset = 1'b0;
    request_phase(0);

    // reset while in WAIT, then a stale response in IDLE
    next_pc_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("wait_rst_req", 32'(imem_req_valid), 32'd0);
    check("wait_rst_count", retired_count, 32'd0);
    tick();
    fetch_enable = 1'b0;
    reset = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'hCAFE_F00D;
    tick();
    imem_resp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("stale_no_instr", 32'(instr_valid), 32'd0);
      check("stale_no_req", 32'(imem_req_valid), 32'd0);
      check("stale_instr", instr, 32'd0);
      tick();
    end
    fetch_enable = 1'b1;
    request_phase(0);
    response_issue(32'h0000_0001, 0, 0);
    exec_phase(0, 32'h0000_0104);

    // retired_count wrap
    request_phase(0);
    response_issue(32'h0000_0002, 0, 0);
    force dut.retired_count_r = 32'hFFFF_FFFF;
    #1;
    release dut.retired_count_r;
    model_retired = 32'hFFFF_FFFF;
    exec_phase(0, 32'h0000_0108);
    check("wrap_zero", retired_count, 32'd0);

    // randomized traffic
    for (int k = 0; k < 30; k++) begin
      npc = $urandom();
      npc[1:0] = 2'b00;
      if (k == 10) npc = 32'hFFFF_FFFC;
      request_phase(int'($urandom_range(0, 3)));
      response_issue($urandom(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      exec_phase(int'($urandom_range(0, 3)), npc);
      if ($urandom_range(0, 2) == 0) begin
        fetch_enable = 1'b0;
        for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
          tick();
          check("stall_no_req", 32'(imem_req_valid), 32'd0);
        end
        fetch_enable = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_sequencer.md
Name: instr_fetch_sequencer

Overview:
- Owns the program counter of the multi-cycle core and issues instruction fetches to instruction memory over a valid/ready request channel.
- Delivers each fetched word with its address to decode.
- Waits for the branch unit's next-PC result before fetching again.
- It is the producer of the instruction address that the branch unit consumes, and the consumer of the next PC the branch unit produces.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- ADDR_W, 32, address/PC width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- fetch_enable  input  1  allows a new fetch to start; sampled in IDLE only.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  ADDR_W  fetch address (current PC).
- imem_resp_valid  input  1  response word valid, single-cycle pulse.
- imem_resp_data  input  32  fetched instruction.
- instr_valid  output  1  instruction available to decode.
- instr_ready  input  1  decode accepts instruction.
- instr  output  32  held instruction word.
- instr_addr  output  ADDR_W  PC of held instruction.
- next_pc_valid  input  1  branch unit result valid (instruction completed).
- next_pc  input  ADDR_W  next PC from branch unit.
- misaligned_err  output  1  sticky: next_pc[1:0] != 0 was received.
- retired_count  output  32  completed-instruction counter.

Behaviour:
- Reset (async, immediate): state=IDLE, pc=RESET_PC, instr=0, instr_addr=RESET_PC, misaligned_err=0, retired_count=0. All valids are 0.
- Reset mid-operation aborts any outstanding request. A response arriving after reset deasserts while still in IDLE is ignored.
- States: IDLE, REQ, WAIT, ISSUE, EXEC, FAULT.
- IDLE:
  - fetch_enable=1 -> REQ next cycle.
  - Otherwise stay in IDLE.
- REQ:
  - imem_req_valid=1 and imem_req_addr=pc.
  - Address is stable while valid is high and ready is low.
  - imem_req_valid && imem_req_ready -> WAIT.
- WAIT:
  - On imem_resp_valid, capture instr<=imem_resp_data and instr_addr<=pc, then -> ISSUE.
  - Minimum request-to-instr_valid latency is 2 cycles after acceptance, with a zero-wait memory responding the cycle after acceptance.
  - A response in REQ or the acceptance cycle itself is illegal and is not captured.
- ISSUE:
  - instr_valid=1; instr and instr_addr are held stable until the handshake.
  - instr_valid && instr_ready -> EXEC.
- EXEC:
  - Wait for next_pc_valid. next_pc_valid is ignored in every other state.
  - next_pc[1:0]==0: pc<=next_pc, retired_count+=1 (wraps 2^32-1 -> 0), then -> IDLE.
  - Misaligned: misaligned_err<=1, pc unchanged, retired_count unchanged, then -> FAULT.
- FAULT:
  - Terminal; all valids are 0 and misaligned_err stays 1.
  - Exit only via reset.
- Loop rate: IDLE is a one-cycle gap, so back-to-back instructions with fetch_enable held high cost ≥5 cycles each.
- fetch_enable low only stalls entry from IDLE; an in-flight fetch completes.
- All outputs are registered except imem_req_valid, imem_req_addr and instr_valid, which are decoded from state and registers, with no input-to-output combinational path.
- PC arithmetic is not performed here; PC+4 comes from the branch unit. Next-PC values wrap naturally at 2^ADDR_W.

Test Plan:
- Reset with RESET_PC=32'h100, fetch_enable=1, memory ready=1, returns 32'h00500093 one cycle later -> imem_req_addr=32'h100; instr_valid rises 2 cycles after acceptance with instr=32'h00500093, instr_addr=32'h100.
- In EXEC drive next_pc=32'h104 -> retired_count=1; next request at 32'h104. Repeat with next_pc=32'h80 (taken branch) -> request at 32'h80.
- Hold imem_req_ready=0 for 3 cycles, then instr_ready=0 for 4 cycles -> imem_req_addr and instr/instr_addr constant throughout; no duplicate request.
- next_pc=32'h106 -> misaligned_err=1, no further imem_req_valid for 20 cycles; reset clears misaligned_err and restarts at RESET_PC.
- Assert reset while in WAIT, release, then pulse imem_resp_valid while fetch_enable=0 -> instr_valid stays 0, state IDLE.
- Preload retired_count near wrap (force 32'hFFFF_FFFF), complete one instruction -> retired_count=0.
